// File: rtl/collatz_range_engine.sv
// Collatz sequence-length engine: evaluates RAM_WORDS consecutive start values and serves results by address.
// Optional build macro COLLATZ_PERF_EN adds the 'cycles' run-length performance counter port.
module collatz_range_engine #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [31:0]              start,
  input  logic [RAM_ADDR_BITS-1:0] n,
  output logic                     done,
  output logic [15:0]              count
`ifdef COLLATZ_PERF_EN
  ,
  output logic [31:0]              cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  // One Collatz step; the 34-bit width keeps the 3v+1 carry visible for overflow detection
  function automatic logic [33:0] collatz_step(input logic [33:0] v);
    if (v[0]) begin
      return (v * 34'd3) + 34'd1;
    end else begin
      return v >> 1;
    end
  endfunction

  state_t                   state_r;
  state_t                   state_s;
  logic [31:0]              base_r;
  logic [RAM_ADDR_BITS-1:0] index_r;
  logic [33:0]              val_r;
  logic [15:0]              len_r;
  logic                     done_r;
  logic [15:0]              count_r;
  logic [33:0]              load_val_s;
  logic [33:0]              step_s;
  logic                     sat_s;
  logic                     last_s;
  logic                     accept_s;
  logic                     ram_we_s;
  logic                     busy_s;
  logic [15:0]              ram [RAM_WORDS];

  assign load_val_s = {2'b00, base_r + 32'(index_r)};
  assign step_s     = collatz_step(val_r);
  assign last_s     = (index_r == LAST_IDX);

  // Saturation: 3v+1 spilled past 32 bits, or the length would hit the 16'hFFFF ceiling
  always_comb begin
    sat_s = 1'b0;
    if (val_r != 34'd1) begin
      sat_s = (val_r[0] && (step_s[33:32] != 2'b00)) || (len_r == 16'hFFFE);
    end else begin
      sat_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = go ? S_LOAD : S_IDLE;
      S_LOAD:  state_s = (load_val_s == 34'd0) ? S_STORE : S_ITER;
      S_ITER:  state_s = ((val_r == 34'd1) || sat_s) ? S_STORE : S_ITER;
      S_STORE: state_s = last_s ? S_DONE : S_LOAD;
      S_DONE:  state_s = go ? S_LOAD : S_DONE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept_s = 1'b0;
    ram_we_s = 1'b0;
    busy_s   = 1'b0;
    case (state_r)
      S_IDLE:  accept_s = go;
      S_LOAD:  busy_s   = 1'b1;
      S_ITER:  busy_s   = 1'b1;
      S_STORE: begin
        ram_we_s = 1'b1;
        busy_s   = 1'b1;
      end
      S_DONE:  accept_s = go;
      default: accept_s = 1'b0;
    endcase
  end

  // Datapath: base/index latching, per-word value and length tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r  <= 32'd0;
      index_r <= '0;
      val_r   <= 34'd0;
      len_r   <= 16'd0;
    end else begin
      if (accept_s) begin
        base_r  <= start;
        index_r <= '0;
      end
      case (state_r)
        S_LOAD: begin
          val_r <= load_val_s;
          len_r <= (load_val_s == 34'd0) ? 16'd0 : 16'd1;
        end
        S_ITER: begin
          if (val_r != 34'd1) begin
            if (sat_s) begin
              len_r <= 16'hFFFF;
            end else begin
              val_r <= step_s;
              len_r <= len_r + 16'd1;
            end
          end
        end
        S_STORE: begin
          if (!last_s) begin
            index_r <= index_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result RAM write port (contents deliberately survive reset)
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram[index_r] <= len_r;
    end
  end

  // Registered read port feeding the display
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 16'd0;
    end else begin
      count_r <= ram[n];
    end
  end

  // done tracks the state being entered, so it rises leaving the last STORE and drops on restart
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_s == S_DONE);
    end
  end

  assign done  = done_r;
  assign count = count_r;

`ifdef COLLATZ_PERF_EN
  logic [31:0] cycles_r;

  // Busy-cycle counter: cleared on accept, saturating, frozen outside a run
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_r <= 32'd0;
    end else if (accept_s) begin
      cycles_r <= 32'd0;
    end else if (busy_s && (cycles_r != 32'hFFFF_FFFF)) begin
      cycles_r <= cycles_r + 32'd1;
    end else begin
      cycles_r <= cycles_r;
    end
  end

  assign cycles = cycles_r;
`endif

endmodule
